// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types, defaults and helpers for the UART receive path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default bit period: 50 MHz system clock at 115200 baud.
  localparam int UART_CLKS_PER_BIT = 434;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  // Two-out-of-three majority, used to reject single-sample line glitches.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : bit_sync
// Brief    : Multi-flop synchronizer for one asynchronous input. Flops reset
//            to 1 so an idle-high serial line looks idle out of reset.
// Revision : 1.0 - initial release
// ============================================================================
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw input one stage further down the chain each cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Chain storage, asynchronously preset to the idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule : bit_sync
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART receiver. Oversampling counter, 3-sample majority vote
//            per bit, framing-error detection and a break state that keeps a
//            held-low line from re-triggering.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy,
  output logic       led_rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP0 = CNT_W'(CLKS_PER_BIT - 3);
  localparam logic [CNT_W-1:0] CNT_SAMP1 = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [1:0]       WARM_END  = 2'(SYNC_STAGES);

  logic           rxs;
  logic           vote;
  logic           warm_done;

  uart_rx_state_e state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shreg_q,   shreg_d;
  logic [1:0]     samp_q,    samp_d;
  logic [7:0]     data_q,    data_d;
  logic           valid_q,   valid_d;
  logic           ferr_q,    ferr_d;
  logic           led_q,     led_d;
  logic           armed_q,   armed_d;
  logic [1:0]     warm_q,    warm_d;

  bit_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  // The synchronizer's preset ones are not a real observation of the line,
  // so arming waits until the chain has been refilled from the pin.
  assign warm_done = (warm_q == WARM_END);

  // Third vote is the live sample taken on the last cycle of the bit.
  assign vote = maj3(samp_q[0], samp_q[1], rxs);

  // Next-state, counter, shift register and output-pulse logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    samp_d    = samp_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    led_d     = led_q;
    armed_d   = armed_q | (warm_done & rxs);
    warm_d    = warm_done ? warm_q : warm_q + 2'd1;

    if (cnt_q == CNT_SAMP0) samp_d[0] = rxs;
    if (cnt_q == CNT_SAMP1) samp_d[1] = rxs;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && !rxs) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rxs ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {vote, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (vote) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            led_d   = ~led_q;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end

      BREAK: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // All receiver state, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      samp_q    <= 2'b11;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      led_q     <= 1'b0;
      armed_q   <= 1'b0;
      warm_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      samp_q    <= samp_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      led_q     <= led_d;
      armed_q   <= armed_d;
      warm_q    <= warm_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != IDLE);
  assign led_rx       = led_q;

endmodule : uart_rx_byte
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_byte
// Brief    : Self-checking bench for uart_rx_byte. Frames are driven bit by
//            bit; a frame-level model predicts each pulse's cycle and payload.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

  localparam int C   = 16;
  localparam int S   = 2;
  localparam int LAT = S + C / 2 + 9 * C;

  typedef struct {
    int         cyc;
    bit         good;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;
  logic       led_rx;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  ev_t        exp_q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_led  = 1'b0;

  uart_rx_byte #(
    .CLKS_PER_BIT (C),
    .SYNC_STAGES  (S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy),
    .led_rx       (led_rx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_rx_data",  {24'd0, rx_data},      32'h00);
    check_eq("rst_rx_valid", {31'd0, rx_valid},     32'd0);
    check_eq("rst_frame_err",{31'd0, rx_frame_err}, 32'd0);
    check_eq("rst_rx_busy",  {31'd0, rx_busy},      32'd0);
    check_eq("rst_led_rx",   {31'd0, led_rx},       32'd0);
  endtask

  // Frame-level model: each decoded frame produces exactly one pulse at its
  // predicted cycle; a good frame updates the held byte and toggles the LED.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      exp_q.delete();
      m_data = 8'h00;
      m_led  = 1'b0;
    end else begin
      if (rx_busy) busy_cnt++;
      if (rx_valid || rx_frame_err) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pulse", {30'd0, rx_valid, rx_frame_err}, 32'd0);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          check_eq("pulse_kind", {30'd0, rx_valid, rx_frame_err}, ev.good ? 32'd2 : 32'd1);
          check_eq("pulse_cycle", cyc, ev.cyc);
          if (ev.good) begin
            m_data = ev.data;
            m_led  = ~m_led;
          end
          check_eq("rx_data", {24'd0, rx_data}, {24'd0, m_data});
          check_eq("led_rx", {31'd0, led_rx}, {31'd0, m_led});
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      rx = v;
    end
  endtask

  // Drives one 8N1 frame. glitch_off inverts one cycle of every data bit at
  // that offset (-1: none); rst_at pulses reset at that frame cycle (-1: none).
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int glitch_off,
                            input bit expect_it, input int rst_at);
    logic v;
    for (int t = 0; t < 10 * C; t++) begin
      int k;
      k = t / C;
      @(negedge clk);
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = stop_ok;
      else             v = b[k-1];
      if (k >= 1 && k <= 8 && (t % C) == glitch_off) v = ~v;
      rx = v;
      if (t == 0 && expect_it) exp_q.push_back('{cyc + 1 + LAT, stop_ok, b});
      if (t == rst_at) begin
        rst = 1'b0;
        #1;
        check_reset_outputs();
      end
      if (rst_at >= 0 && t == rst_at + 3) rst = 1'b1;
    end
  endtask

  initial begin
    int b0;
    rst = 1'b0;
    rx  = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 10);

    // Single clean frame.
    send_frame(8'hA5, 1'b1, -1, 1'b1, -1);
    drive(1'b1, 20);
    check_eq("a5_data", {24'd0, rx_data}, 32'hA5);
    check_eq("a5_led", {31'd0, led_rx}, 32'd1);

    // Short low glitch on an idle line: brief START, no pulse.
    b0 = busy_cnt;
    drive(1'b0, 3);
    drive(1'b1, 30);
    check_eq("glitch_busy_window", {31'd0, (busy_cnt - b0 >= 1) && (busy_cnt - b0 <= 10)}, 32'd1);

    // Bad stop bit followed by a long break, then a good frame.
    send_frame(8'h3C, 1'b0, -1, 1'b1, -1);
    drive(1'b0, 40 * C);
    check_eq("break_data_held", {24'd0, rx_data}, 32'hA5);
    drive(1'b1, 10);
    send_frame(8'h01, 1'b1, -1, 1'b1, -1);
    drive(1'b1, 10);

    // Back-to-back frames with a one-cycle glitch in every data bit.
    send_frame(8'h00, 1'b1, 2, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 13, 1'b1, -1);
    send_frame(8'h55, 1'b1, 7, 1'b1, -1);
    check_eq("b2b_led", {31'd0, led_rx}, 32'd1);
    check_eq("b2b_data", {24'd0, rx_data}, 32'h55);
    drive(1'b1, 10);

    // Reset in the middle of data bit 4, released while the line is low.
    send_frame(8'hC3, 1'b1, -1, 1'b0, 5 * C + 5);
    drive(1'b1, 10);
    send_frame(8'h7E, 1'b1, -1, 1'b1, -1);
    drive(1'b1, 10);

    // Line held low through reset release: must stay unarmed.
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    b0 = busy_cnt;
    drive(1'b0, 4 * C);
    check_eq("held_low_busy", busy_cnt - b0, 32'd0);
    drive(1'b1, 20);
    send_frame(8'h81, 1'b1, -1, 1'b1, -1);
    drive(1'b1, 10);
    check_eq("h81_data", {24'd0, rx_data}, 32'h81);

    // Randomized frames, gaps, glitch positions and occasional bad stop bits.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      bit         ok;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok, int'($urandom_range(0, C - 1)), 1'b1, -1);
      if (!ok) begin
        drive(1'b0, int'($urandom_range(0, 3 * C)));
        drive(1'b1, int'($urandom_range(4, 20)));
      end else begin
        drive(1'b1, int'($urandom_range(0, 20)));
      end
    end

    drive(1'b1, 3 * C);
    check_eq("pending_events", exp_q.size(), 32'd0);
    check_eq("final_led", {31'd0, led_rx}, {31'd0, m_led});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_rx_byte
`default_nettype wire
